// File: rtl/sr_ff_checker_pkg.sv
// -----------------------------------------------------------------------------
// sr_chk_pkg
//   Shared encodings for the SR flip-flop checker.
//   - chk_state_e : checker FSM state, as seen on the 2-bit state output
//   - sr_cmd_e    : {s, r} command pair sampled from the observed flip-flop
// -----------------------------------------------------------------------------
package sr_chk_pkg;

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'b00,
        ST_TRACK   = 2'b01,
        ST_FAULT   = 2'b10
    } chk_state_e;

    typedef enum logic [1:0] {
        CMD_HOLD = 2'b00,
        CMD_RST  = 2'b01,
        CMD_SET  = 2'b10,
        CMD_BAD  = 2'b11
    } sr_cmd_e;

endpackage

// File: rtl/sr_ff_checker_if.sv
// -----------------------------------------------------------------------------
// sr_ff_checker_if
//   Groups the observed flip-flop signals and the checker results.
//   Observed / control (driven by master): clr, en, s, r, q
//   Results (driven by slave = checker):   exp_q, state, mismatch, illegal,
//                                          err_sticky, chk_count, err_count
//   There is no handshake: every signal is a level sampled on the rising
//   clock edge when en=1; clr acts regardless of en.
// -----------------------------------------------------------------------------
interface sr_ff_checker_if #(
    parameter int CNT_W = 8
) ();
    logic             clr;
    logic             en;
    logic             s;
    logic             r;
    logic             q;
    logic             exp_q;
    logic [1:0]       state;
    logic             mismatch;
    logic             illegal;
    logic             err_sticky;
    logic [CNT_W-1:0] chk_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output clr, en, s, r, q,
        input  exp_q, state, mismatch, illegal, err_sticky, chk_count, err_count
    );

    modport slave (
        input  clr, en, s, r, q,
        output exp_q, state, mismatch, illegal, err_sticky, chk_count, err_count
    );
endinterface

// File: rtl/sr_ff_checker_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter, adds 0..3 per clock and clamps at 2**W-1.
//   Ports:
//     clk  : clock
//     rst  : asynchronous active-high reset to 0
//     clr  : synchronous clear to 0, wins over inc
//     inc  : amount to add this cycle
//     cnt  : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [1:0]   inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W:0]   sum;

    // One extra bit catches the carry; a carry means we passed all-ones.
    always_comb begin
        sum   = {1'b0, cnt_q} + (W+1)'(inc);
        cnt_d = sum[W] ? {W{1'b1}} : sum[W-1:0];
        if (clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/sr_ff_checker.sv
// -----------------------------------------------------------------------------
// sr_ff_checker
//   Monitors an SR flip-flop: keeps a reference model of q, compares the
//   observed q against it, flags forbidden s=r=1 commands and counts checks
//   and errors. Stops (FAULT) once err_count reaches MAX_ERR.
//   Ports:
//     clk : clock, rising edge
//     rst : asynchronous active-high reset
//     bus : sr_ff_checker_if.slave (clr/en/s/r/q in, results out;
//           state output exposes the FSM)
// -----------------------------------------------------------------------------
module sr_ff_checker
    import sr_chk_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int MAX_ERR = 4
) (
    input logic              clk,
    input logic              rst,
    sr_ff_checker_if.slave   bus
);
    localparam logic [CNT_W-1:0] MAX_ERR_C = CNT_W'(MAX_ERR);

    chk_state_e       state_q, state_d;
    logic             exp_q_q, exp_q_d;
    logic             mismatch_q, mismatch_d;
    logic             illegal_q, illegal_d;
    logic             sticky_q, sticky_d;
    logic [1:0]       chk_inc;
    logic [1:0]       err_inc;
    logic [CNT_W-1:0] chk_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W:0]   err_sum;
    logic [CNT_W-1:0] err_next;
    sr_cmd_e          cmd;

    assign cmd = sr_cmd_e'({bus.s, bus.r});

    // err_count as it will stand after this edge; decides FAULT entry.
    always_comb begin
        err_sum  = {1'b0, err_cnt} + (CNT_W+1)'(err_inc);
        err_next = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        exp_q_d    = exp_q_q;
        mismatch_d = 1'b0;
        illegal_d  = 1'b0;
        sticky_d   = sticky_q;
        chk_inc    = 2'd0;
        err_inc    = 2'd0;

        if (bus.clr) begin
            state_d  = ST_UNKNOWN;
            exp_q_d  = 1'b0;
            sticky_d = 1'b0;
        end else if (bus.en && state_q != ST_FAULT) begin
            // Compare phase: q at this edge reflects the command of the
            // previous edge, so it is checked against the pre-update model.
            // In UNKNOWN q is not looked at, so X/Z there is harmless.
            if (state_q == ST_TRACK) begin
                chk_inc = 2'd1;
                if (bus.q != exp_q_q) begin
                    mismatch_d = 1'b1;
                    err_inc    = err_inc + 2'd1;
                    sticky_d   = 1'b1;
                end
            end

            // Update phase from the sampled command.
            case (cmd)
                CMD_HOLD: ;
                CMD_RST: begin
                    exp_q_d = 1'b0;
                    state_d = ST_TRACK;
                end
                CMD_SET: begin
                    exp_q_d = 1'b1;
                    state_d = ST_TRACK;
                end
                CMD_BAD: begin
                    illegal_d = 1'b1;
                    err_inc   = err_inc + 2'd1;
                    sticky_d  = 1'b1;
                    state_d   = ST_UNKNOWN;
                end
                default: ;
            endcase

            if (err_next >= MAX_ERR_C) begin
                state_d = ST_FAULT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_UNKNOWN;
            exp_q_q    <= 1'b0;
            mismatch_q <= 1'b0;
            illegal_q  <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_q_q    <= exp_q_d;
            mismatch_q <= mismatch_d;
            illegal_q  <= illegal_d;
            sticky_q   <= sticky_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_chk_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.clr),
        .inc (chk_inc),
        .cnt (chk_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.clr),
        .inc (err_inc),
        .cnt (err_cnt)
    );

    assign bus.exp_q      = exp_q_q;
    assign bus.state      = state_q;
    assign bus.mismatch   = mismatch_q;
    assign bus.illegal    = illegal_q;
    assign bus.err_sticky = sticky_q;
    assign bus.chk_count  = chk_cnt;
    assign bus.err_count  = err_cnt;
endmodule

// File: tb/tb_sr_ff_checker.sv
// -----------------------------------------------------------------------------
// tb_sr_ff_checker
//   Directed bench for sr_ff_checker. dut0 uses CNT_W=8/MAX_ERR=4, dut1 uses
//   CNT_W=2/MAX_ERR=3 for the saturation case. Inputs change 1 time unit
//   after each rising edge; outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_sr_ff_checker;
    logic clk;
    logic rst;
    int   checks;
    int   passes;
    int   fails;
    logic ff_q [2];

    sr_ff_checker_if #(.CNT_W(8)) if0 ();
    sr_ff_checker_if #(.CNT_W(2)) if1 ();

    sr_ff_checker #(.CNT_W(8), .MAX_ERR(4)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    sr_ff_checker #(.CNT_W(2), .MAX_ERR(3)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input int which, input string tag,
                             input logic [1:0] st, input logic eq,
                             input logic mis, input logic ill, input logic stk,
                             input logic [7:0] cc, input logic [7:0] ec);
        logic [1:0] o_st;
        logic       o_eq, o_mis, o_ill, o_stk;
        logic [7:0] o_cc, o_ec;
        if (which == 0) begin
            o_st = if0.state; o_eq = if0.exp_q; o_mis = if0.mismatch;
            o_ill = if0.illegal; o_stk = if0.err_sticky;
            o_cc = if0.chk_count; o_ec = if0.err_count;
        end else begin
            o_st = if1.state; o_eq = if1.exp_q; o_mis = if1.mismatch;
            o_ill = if1.illegal; o_stk = if1.err_sticky;
            o_cc = {6'd0, if1.chk_count}; o_ec = {6'd0, if1.err_count};
        end
        chk({tag, ".state"},     {6'd0, o_st},  {6'd0, st});
        chk({tag, ".exp_q"},     {7'd0, o_eq},  {7'd0, eq});
        chk({tag, ".mismatch"},  {7'd0, o_mis}, {7'd0, mis});
        chk({tag, ".illegal"},   {7'd0, o_ill}, {7'd0, ill});
        chk({tag, ".sticky"},    {7'd0, o_stk}, {7'd0, stk});
        chk({tag, ".chk_count"}, o_cc, cc);
        chk({tag, ".err_count"}, o_ec, ec);
    endtask

    // ---------------- drivers ----------------
    // One enabled edge. q comes from the stimulus flip-flop unless forced.
    task automatic step(input int which, input logic s, input logic r,
                        input bit frc, input logic fq);
        logic qv;
        qv = frc ? fq : ff_q[which];
        if (which == 0) begin
            if0.s = s; if0.r = r; if0.q = qv; if0.en = 1'b1;
        end else begin
            if1.s = s; if1.r = r; if1.q = qv; if1.en = 1'b1;
        end
        @(posedge clk);
        #1;
        if (s && !r)      ff_q[which] = 1'b1;
        else if (!s && r) ff_q[which] = 1'b0;
        if0.en = 1'b0;
        if1.en = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        if0.clr = 1'b0; if0.en = 1'b0; if0.s = 1'b0; if0.r = 1'b0; if0.q = 1'b0;
        if1.clr = 1'b0; if1.en = 1'b0; if1.s = 1'b0; if1.r = 1'b0; if1.q = 1'b0;
        ff_q[0] = 1'b0;
        ff_q[1] = 1'b0;
        @(posedge clk);
        #1;
        check_all(0, tag, 2'b00, 0, 0, 0, 0, 8'd0, 8'd0);
        rst = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        checks = 0;
        passes = 0;
        fails  = 0;
        rst    = 1'b1;

        // Basic tracking with a correct flip-flop.
        do_reset("t1_rst");
        step(0, 1, 0, 0, 0); check_all(0, "t1_e1", 2'b01, 1, 0, 0, 0, 8'd0, 8'd0);
        step(0, 0, 0, 0, 0); check_all(0, "t1_e2", 2'b01, 1, 0, 0, 0, 8'd1, 8'd0);
        step(0, 0, 0, 0, 0); check_all(0, "t1_e3", 2'b01, 1, 0, 0, 0, 8'd2, 8'd0);
        step(0, 0, 0, 0, 0); check_all(0, "t1_e4", 2'b01, 1, 0, 0, 0, 8'd3, 8'd0);

        // 00,01,10,11,10,01 command sequence.
        do_reset("t2_rst");
        step(0, 0, 0, 0, 0); check_all(0, "t2_00", 2'b00, 0, 0, 0, 0, 8'd0, 8'd0);
        step(0, 0, 1, 0, 0); check_all(0, "t2_01", 2'b01, 0, 0, 0, 0, 8'd0, 8'd0);
        step(0, 1, 0, 0, 0); check_all(0, "t2_10", 2'b01, 1, 0, 0, 0, 8'd1, 8'd0);
        step(0, 1, 1, 0, 0); check_all(0, "t2_11", 2'b00, 1, 0, 1, 1, 8'd2, 8'd1);
        step(0, 1, 0, 0, 0); check_all(0, "t2_10b", 2'b01, 1, 0, 0, 1, 8'd2, 8'd1);
        step(0, 0, 1, 0, 0); check_all(0, "t2_01b", 2'b01, 0, 0, 0, 1, 8'd3, 8'd1);

        // Single forced mismatch, then en=0 hold.
        do_reset("t3_rst");
        step(0, 1, 0, 0, 0); check_all(0, "t3_set", 2'b01, 1, 0, 0, 0, 8'd0, 8'd0);
        step(0, 0, 0, 1, 0); check_all(0, "t3_mis", 2'b01, 1, 1, 0, 1, 8'd1, 8'd1);
        if0.en = 1'b0; if0.s = 1'b1; if0.r = 1'b1; if0.q = 1'b0;
        @(posedge clk); #1;
        check_all(0, "t3_en0", 2'b01, 1, 0, 0, 1, 8'd1, 8'd1);
        step(0, 0, 0, 0, 0); check_all(0, "t3_ok", 2'b01, 1, 0, 0, 1, 8'd2, 8'd1);

        // clr priority, then drive into FAULT.
        if0.clr = 1'b1; if0.en = 1'b1; if0.s = 1'b1; if0.r = 1'b0;
        @(posedge clk); #1;
        if0.clr = 1'b0; if0.en = 1'b0;
        check_all(0, "t4_clr", 2'b00, 0, 0, 0, 0, 8'd0, 8'd0);
        step(0, 1, 0, 0, 0); check_all(0, "t4_set", 2'b01, 1, 0, 0, 0, 8'd0, 8'd0);
        step(0, 0, 0, 1, 0); check_all(0, "t4_m1", 2'b01, 1, 1, 0, 1, 8'd1, 8'd1);
        step(0, 0, 0, 1, 0); check_all(0, "t4_m2", 2'b01, 1, 1, 0, 1, 8'd2, 8'd2);
        step(0, 0, 0, 1, 0); check_all(0, "t4_m3", 2'b01, 1, 1, 0, 1, 8'd3, 8'd3);
        step(0, 0, 0, 1, 0); check_all(0, "t4_m4", 2'b10, 1, 1, 0, 1, 8'd4, 8'd4);
        step(0, 0, 0, 1, 0); check_all(0, "t4_f1", 2'b10, 1, 0, 0, 1, 8'd4, 8'd4);
        step(0, 1, 1, 1, 0); check_all(0, "t4_f2", 2'b10, 1, 0, 0, 1, 8'd4, 8'd4);
        if0.clr = 1'b1;
        @(posedge clk); #1;
        if0.clr = 1'b0;
        check_all(0, "t4_clr2", 2'b00, 0, 0, 0, 0, 8'd0, 8'd0);

        // Narrow counter: mismatch + illegal on one edge clamps at 3.
        do_reset("t5_rst");
        check_all(1, "t5_rst1", 2'b00, 0, 0, 0, 0, 8'd0, 8'd0);
        step(1, 1, 0, 0, 0); check_all(1, "t5_set", 2'b01, 1, 0, 0, 0, 8'd0, 8'd0);
        step(1, 0, 0, 1, 0); check_all(1, "t5_m1", 2'b01, 1, 1, 0, 1, 8'd1, 8'd1);
        step(1, 0, 0, 1, 0); check_all(1, "t5_m2", 2'b01, 1, 1, 0, 1, 8'd2, 8'd2);
        step(1, 1, 1, 1, 0); check_all(1, "t5_both", 2'b10, 1, 1, 1, 1, 8'd3, 8'd3);
        step(1, 0, 0, 1, 0); check_all(1, "t5_after", 2'b10, 1, 0, 0, 1, 8'd3, 8'd3);

        // Asynchronous reset mid-cycle while tracking.
        do_reset("t6_rst");
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0); check_all(0, "t6_pre", 2'b01, 1, 1, 0, 1, 8'd2, 8'd2);
        #3 rst = 1'b1;
        #1 check_all(0, "t6_async", 2'b00, 0, 0, 0, 0, 8'd0, 8'd0);
        #1 rst = 1'b0;
        step(0, 0, 0, 1, 0); check_all(0, "t6_hold", 2'b00, 0, 0, 0, 0, 8'd0, 8'd0);
        step(0, 0, 1, 0, 0); check_all(0, "t6_rstcmd", 2'b01, 0, 0, 0, 0, 8'd0, 8'd0);
        step(0, 0, 0, 0, 0); check_all(0, "t6_cmp", 2'b01, 0, 0, 0, 0, 8'd1, 8'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
